seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter: W, 4, divisor width; dividend and quotient are 2W bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a division; sampled on clk.
REQ-005 SHALL have port: a  input  2W  unsigned dividend; sampled with start.
REQ-006 SHALL have port: b  input  W  unsigned divisor; sampled with start.
REQ-007 SHALL have port: busy  output  1  high while the division is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; q and r valid.
REQ-009 SHALL have port: q  output  2W  quotient, floor(a/b).
REQ-010 SHALL have port: r  output  W  remainder, a mod b.

Function
REQ-011 SHALL be a restoring radix-2 divider producing one quotient bit per cycle, MSB first.
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL follow these FSM transitions:
- IDLE --start--> RUN;
- RUN --after 2W steps--> DONE;
- DONE --start--> RUN;
- DONE --no start--> IDLE.
REQ-014 SHALL capture a and b internally when start is accepted; later input changes SHALL have no effect.
REQ-015 SHALL assert busy exactly while in RUN.
REQ-016 SHALL ignore start while busy=1 (no restart, no queueing).
REQ-017 SHALL perform one step per RUN cycle: partial remainder (W+1 bits) = {rem, next dividend bit}; if it is >= b, subtract b and set the quotient bit to 1, else set it to 0.
REQ-018 SHALL assert done exactly 2W+1 cycles after the accepting edge (9 cycles for W=4).
REQ-019 SHALL assert done for exactly one cycle.
REQ-020 SHALL hold q and r stable from done until the next accepted start.
REQ-021 SHALL accept a start asserted in the DONE cycle, giving back-to-back operation with no idle gap.
REQ-022 SHALL, for b=0 without the Configuration feature, run the normal 2W steps and yield q = all ones and r = a[W-1:0].
REQ-023 SHALL satisfy q*b + r == a and r < b for every b != 0.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, busy=0, done=0, q=0, r=0 and step counter 0, regardless of clk.
REQ-025 SHALL abandon any division in progress on reset, with no done pulse afterwards.
REQ-026 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL use macro SEQ_DIV_DIVZ_ERR_EN.
REQ-028 SHALL, when SEQ_DIV_DIVZ_ERR_EN is defined:
- add port err  output  1, asserted only together with done when b==0 at acceptance;
- on b==0, skip RUN and go directly to DONE, so done occurs 1 cycle after acceptance;
- drive q = all ones and r = a[W-1:0];
- reset err to 0.
REQ-029 SHALL, when SEQ_DIV_DIVZ_ERR_EN is undefined, have no err port and behave per REQ-022.

Structure
REQ-030 SHALL place the FSM state enum typedef (IDLE/RUN/DONE) and the default width constant in shared package seq_div_pkg.
REQ-031 SHALL implement the combinational compare/subtract step as sub-module div_step (inputs: partial remainder, divisor; outputs: new remainder, quotient bit), instantiated once.

Verification (W=4)
REQ-032 SHALL cover: a=200, b=13, start pulse -> busy for 8 cycles, done at +9, q=15, r=5.
REQ-033 SHALL cover: a=255, b=1 -> q=255, r=0; a=7, b=9 -> q=0, r=7.
REQ-034 SHALL cover: a=100, b=0 -> without macro, q=255 and r=4 at +9; with macro, done and err at +1, q=255, r=4.
REQ-035 SHALL cover: start held during RUN with different a/b -> result matches the first operands; a start in the DONE cycle -> second done exactly 9 cycles later.
REQ-036 SHALL cover: rst_n low at step 4 -> outputs 0 immediately, no done pulse; a new start after release completes correctly.
REQ-037 SHALL cover round-trip with the unsigned array multiplier: 10 random x, y with y != 0, a = x*y, b = y -> q=x, r=0 each time, reporting PASS/FAIL per case.

Source files
------------

// File: rtl/seq_div_pkg.sv
// seq_div_pkg -- shared types and constants for the sequential divider.
//   W_DEF   : default divisor width (dividend/quotient are 2*W_DEF bits)
//   state_t : controller state encoding (IDLE / RUN / DONE)
package seq_div_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_step.sv
// div_step -- one restoring-division step (compare and conditional subtract).
//   part     in  W+1  partial remainder {rem, next dividend bit}
//   div      in  W    divisor
//   rem_next out W    new partial remainder
//   qbit     out 1    quotient bit produced by this step
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   part,
  input  logic [W-1:0] div,
  output logic [W-1:0] rem_next,
  output logic         qbit
);

  assign qbit = (part >= {1'b0, div});

  // When the subtract happens the result is < div, so it always fits in W bits.
  // For div == 0 the subtract is a no-op and the dividend bits just shift through.
  assign rem_next = qbit ? W'(part - {1'b0, div}) : part[W-1:0];

endmodule

// File: rtl/seq_div.sv
// seq_div -- restoring radix-2 unsigned divider, one quotient bit per cycle (MSB first).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a division (ignored while busy)
//   a, b       : 2W-bit dividend, W-bit divisor, captured when start is accepted
//   busy       : high while the division runs (RUN state)
//   done       : one-cycle pulse, q/r valid; q/r hold until the next result
//   q, r       : quotient floor(a/b), remainder a mod b
//   err        : only with SEQ_DIV_DIVZ_ERR_EN defined -- pulses with done when b==0;
//                that build also skips the RUN phase for a zero divisor.
// Division by zero otherwise runs the normal 2W steps, giving q = all ones, r = a[W-1:0].
module seq_div
  import seq_div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
`ifdef SEQ_DIV_DIVZ_ERR_EN
  output logic           err,
`endif
  output logic [2*W-1:0] q,
  output logic [W-1:0]   r
);

  localparam int             CW   = $clog2(2*W) + 1;
  localparam logic [CW-1:0]  LAST = CW'(2*W-1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] dvd;       // remaining dividend bits, quotient bits shift in at the bottom
  logic [W-1:0]   rem;
  logic [W-1:0]   b_r;
  logic [2*W-1:0] q_r;
  logic [W-1:0]   r_r;
  logic [W-1:0]   rem_next;
  logic           qbit;
  logic           accept;
  logic           last;
  logic           divz;

  assign accept = start && (state != RUN);
  assign last   = (cnt == LAST);

`ifdef SEQ_DIV_DIVZ_ERR_EN
  assign divz = (b == '0);
`else
  assign divz = 1'b0;
`endif

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? (divz ? DONE : RUN) : IDLE;
      RUN:        if (last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  div_step #(.W(W)) u_step (
    .part     ({rem, dvd[2*W-1]}),
    .div      (b_r),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd <= '0;
      rem <= '0;
      b_r <= '0;
      cnt <= '0;
      q_r <= '0;
      r_r <= '0;
    end else if (accept) begin
      dvd <= a;
      b_r <= b;
      rem <= '0;
      cnt <= '0;
      if (divz) begin
        q_r <= '1;
        r_r <= a[W-1:0];
      end
    end else if (state == RUN) begin
      dvd <= {dvd[2*W-2:0], qbit};
      rem <= rem_next;
      cnt <= cnt + 1'b1;
      // Publish only on the final step so q/r stay stable outside a result update.
      if (last) begin
        q_r <= {dvd[2*W-2:0], qbit};
        r_r <= rem_next;
      end
    end
  end

`ifdef SEQ_DIV_DIVZ_ERR_EN
  logic err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_r <= 1'b0;
    else if (accept) err_r <= divz;
  end

  assign err = done & err_r;
`endif

  assign q = q_r;
  assign r = r_r;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div -- self-checking bench for seq_div (W=4) against an arithmetic reference model.
// Build with SEQ_DIV_DIVZ_ERR_EN defined to exercise the zero-divisor error variant.
module tb_seq_div;

`ifdef SEQ_DIV_DIVZ_ERR_EN
  localparam bit DIVZ = 1'b1;
`else
  localparam bit DIVZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [3:0] r;
  logic       err_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_div #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
`ifdef SEQ_DIV_DIVZ_ERR_EN
    .err   (err_w),
`endif
    .q     (q),
    .r     (r)
  );

`ifndef SEQ_DIV_DIVZ_ERR_EN
  assign err_w = 1'b0;
`endif

  // Reference: plain integer division; zero divisor gives all-ones / low dividend bits.
  function automatic void model(input logic [7:0] av, input logic [3:0] bv,
                                output logic [7:0] eq, output logic [3:0] er,
                                output int lat, output int nerr);
    int rem;
    if (bv == 4'd0) begin
      eq   = 8'hFF;
      er   = av[3:0];
      lat  = DIVZ ? 1 : 9;
      nerr = DIVZ ? 1 : 0;
    end else begin
      eq   = 8'(int'(av) / int'(bv));
      rem  = int'(av) % int'(bv);
      er   = 4'(rem);
      lat  = 9;
      nerr = 0;
    end
  endfunction

  // Issue one start pulse and observe 14 cycles. k counts edges after the accepting
  // edge; the value seen in window k is what edge k samples.
  task automatic do_div(input logic [7:0] av, input logic [3:0] bv,
                        output int kd, output int nbusy, output int ndone, output int nerr,
                        output logic [7:0] qo, output logic [3:0] ro);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = 8'($urandom); b = 4'($urandom);
    kd = 0; nbusy = 0; ndone = 0; nerr = 0; qo = 'x; ro = 'x;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy)  nbusy++;
      if (err_w) nerr++;
      if (done) begin
        ndone++;
        if (kd == 0) begin kd = k; qo = q; ro = r; end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 4'd0;
    #2;
    checks++;
    if ({busy, done, err_w, q, r} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b q=%0d r=%0d want all 0", busy, done, err_w, q, r);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int kd, nb, nd, ne;
    logic [7:0] qo;
    logic [3:0] ro;
    do_div(8'd200, 4'd13, kd, nb, nd, ne, qo, ro);
    checks++;
    if (nb != 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", nb); end
    checks++;
    if (kd != 9) begin errors++; $display("FAIL basic_done_latency got %0d want 9", kd); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL basic_done_width got %0d want 1", nd); end
    checks++;
    if (qo !== 8'd15 || ro !== 4'd5) begin
      errors++; $display("FAIL basic_result got q=%0d r=%0d want q=15 r=5", qo, ro);
    end
    checks++;
    if (q !== 8'd15 || r !== 4'd5) begin
      errors++; $display("FAIL basic_hold got q=%0d r=%0d want q=15 r=5", q, r);
    end
  endtask

  task automatic test_edges;
    logic [7:0] ta [4] = '{8'd255, 8'd7, 8'd0,   8'd255};
    logic [3:0] tb [4] = '{4'd1,   4'd9, 4'd5,   4'd15};
    for (int i = 0; i < 4; i++) begin
      int kd, nb, nd, ne, lat, enerr;
      logic [7:0] qo, eq;
      logic [3:0] ro, er;
      model(ta[i], tb[i], eq, er, lat, enerr);
      do_div(ta[i], tb[i], kd, nb, nd, ne, qo, ro);
      checks++;
      if (kd != lat || qo !== eq || ro !== er) begin
        errors++;
        $display("FAIL edge_%0d a=%0d b=%0d got k=%0d q=%0d r=%0d want k=%0d q=%0d r=%0d",
                 i, ta[i], tb[i], kd, qo, ro, lat, eq, er);
      end
    end
  endtask

  task automatic test_div_zero;
    int kd, nb, nd, ne, lat, enerr;
    logic [7:0] qo, eq;
    logic [3:0] ro, er;
    model(8'd100, 4'd0, eq, er, lat, enerr);
    do_div(8'd100, 4'd0, kd, nb, nd, ne, qo, ro);
    checks++;
    if (kd != lat) begin errors++; $display("FAIL divz_latency got %0d want %0d", kd, lat); end
    checks++;
    if (qo !== eq || ro !== er) begin
      errors++; $display("FAIL divz_result got q=%0d r=%0d want q=%0d r=%0d", qo, ro, eq, er);
    end
    checks++;
    if (ne != enerr) begin errors++; $display("FAIL divz_err_cycles got %0d want %0d", ne, enerr); end
    checks++;
    if (nb != (lat == 9 ? 8 : 0)) begin
      errors++; $display("FAIL divz_busy_cycles got %0d want %0d", nb, (lat == 9 ? 8 : 0));
    end
  endtask

  task automatic test_ignore_start;
    int kd = 0, nd = 0;
    logic [7:0] qo = 'x;
    logic [3:0] ro = 'x;
    @(negedge clk);
    a = 8'd200; b = 4'd13; start = 1'b1;
    @(posedge clk);
    #1 a = 8'd50; b = 4'd3;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 9) start = 1'b0;
      if (done) begin
        nd++;
        if (kd == 0) begin kd = k; qo = q; ro = r; end
      end
    end
    checks++;
    if (kd != 9 || nd != 1 || qo !== 8'd15 || ro !== 4'd5) begin
      errors++;
      $display("FAIL ignore_start got k=%0d ndone=%0d q=%0d r=%0d want k=9 ndone=1 q=15 r=5", kd, nd, qo, ro);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int kd = 0, nd = 0;
    logic [7:0] qo = 'x;
    logic [3:0] ro = 'x;
    logic       d1 = 1'b0;
    logic [7:0] q1 = 'x;
    logic [3:0] r1 = 'x;
    @(negedge clk);
    a = 8'd200; b = 4'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 9) begin
        d1 = done; q1 = q; r1 = r;
        a = 8'd255; b = 4'd1; start = 1'b1;
      end
    end
    checks++;
    if (d1 !== 1'b1 || q1 !== 8'd15 || r1 !== 4'd5) begin
      errors++; $display("FAIL b2b_first got done=%b q=%0d r=%0d want done=1 q=15 r=5", d1, q1, r1);
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (kd == 0) begin kd = k; qo = q; ro = r; end
      end
    end
    checks++;
    if (kd != 9 || nd != 1 || qo !== 8'd255 || ro !== 4'd0) begin
      errors++;
      $display("FAIL b2b_second got k=%0d ndone=%0d q=%0d r=%0d want k=9 ndone=1 q=255 r=0", kd, nd, qo, ro);
    end
  endtask

  task automatic test_reset_midrun;
    int kd = 0, nd = 0;
    logic [7:0] qo = 'x;
    logic [3:0] ro = 'x;
    @(negedge clk);
    a = 8'd200; b = 4'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err_w, q, r} !== 15'd0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b err=%b q=%0d r=%0d want all 0", busy, done, err_w, q, r);
    end
    repeat (2) @(negedge clk);
    // Release and request together: the first edge after release must accept.
    rst_n = 1'b1; a = 8'd77; b = 4'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (kd == 0) begin kd = k; qo = q; ro = r; end
      end
    end
    checks++;
    if (kd != 9 || nd != 1 || qo !== 8'd12 || ro !== 4'd5) begin
      errors++;
      $display("FAIL after_reset got k=%0d ndone=%0d q=%0d r=%0d want k=9 ndone=1 q=12 r=5", kd, nd, qo, ro);
    end
  endtask

  task automatic test_round_trip;
    for (int i = 0; i < 10; i++) begin
      int kd, nb, nd, ne, x, y;
      logic [7:0] qo;
      logic [3:0] ro;
      y = int'($urandom_range(15, 1));
      x = int'($urandom_range(255 / y, 0));
      do_div(8'(x * y), 4'(y), kd, nb, nd, ne, qo, ro);
      checks++;
      if (qo !== 8'(x) || ro !== 4'd0 || kd != 9) begin
        errors++;
        $display("FAIL round_trip_%0d a=%0d b=%0d got q=%0d r=%0d k=%0d want q=%0d r=0 k=9",
                 i, x * y, y, qo, ro, kd, x);
      end else begin
        $display("PASS round_trip_%0d a=%0d b=%0d q=%0d", i, x * y, y, qo);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      int kd, nb, nd, ne, lat, enerr;
      logic [7:0] av, qo, eq;
      logic [3:0] bv, ro, er;
      av = 8'($urandom);
      bv = 4'($urandom);
      model(av, bv, eq, er, lat, enerr);
      do_div(av, bv, kd, nb, nd, ne, qo, ro);
      checks++;
      if (kd != lat || nd != 1 || ne != enerr || qo !== eq || ro !== er) begin
        errors++;
        $display("FAIL random_%0d a=%0d b=%0d got k=%0d nd=%0d ne=%0d q=%0d r=%0d want k=%0d nd=1 ne=%0d q=%0d r=%0d",
                 i, av, bv, kd, nd, ne, qo, ro, lat, enerr, eq, er);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_edges;
    test_div_zero;
    test_ignore_start;
    test_back_to_back;
    test_reset_midrun;
    test_round_trip;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
